// File: rtl/matrix_fb_pkg.sv
// matrix_fb_pkg
// Shared definitions for the panel frame-buffer write side: panel geometry,
// pixel word layout and the write-controller state encoding.
package matrix_fb_pkg;

    localparam int ROWS      = 32;
    localparam int COLS      = 32;
    localparam int FB_WORDS  = 512;   // one page (one buffer) per dpram
    localparam int PIX_BITS  = 12;

    // Pixel word layout {r, g, b}
    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        CLEAR     = 2'd1,
        SWAP_WAIT = 2'd2
    } fb_state_t;

endpackage

// File: rtl/matrix_rr_arb2.sv
// matrix_rr_arb2
// Two-way round-robin arbiter. When both requests are present the one not
// granted last wins; a single request is granted directly. The pointer only
// moves on an actual grant, and nothing is granted while en is low.
// Ports:
//   clk, rst   clock, synchronous active-high reset (pointer favours req[0])
//   en         allow a grant this cycle
//   req[1:0]   request lines
//   gnt[1:0]   one-hot (or zero) combinational grant
module matrix_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // last_q = index of the most recent grant; reset to 1 so req[0] wins first
    logic last_q;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = last_q ? 2'b01 : 2'b10;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else if (gnt[0]) begin
            last_q <= 1'b0;
        end else if (gnt[1]) begin
            last_q <= 1'b1;
        end
    end

endmodule

// File: rtl/matrix_fb_write_ctrl.sv
// matrix_fb_write_ctrl
// Write-side controller for the double-buffered 32x32 panel frame memory.
// Arbitrates two pixel writers onto the single dpram write port, always
// writing the back buffer (~front_buf), and flips buffers only on a
// frame boundary reported by the scan driver.
//
// Build option: define MATRIX_FB_CLEAR_EN to include the CLEAR sweep
// (512 writes of black to the back buffer). Without it clear_req is ignored.
//
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   reqN_valid/ready/row/col/rgb     requester N write handshake (N = 0 host, 1 pattern gen)
//   swap_req                         flip buffers at the next frame_done
//   clear_req                        fill back buffer with 0 (MATRIX_FB_CLEAR_EN)
//   frame_done                       end-of-frame pulse from the scan driver
//   front_buf                        buffer the scan driver reads
//   wr_hi, wr_lo, wr_addr, wr_data   registered dpram write port
//   swap_ack                         pulse in the cycle front_buf toggles
//   busy                             high in CLEAR or SWAP_WAIT
module matrix_fb_write_ctrl
    import matrix_fb_pkg::*;
#(
    parameter int ROW_BITS   = 5,
    parameter int COL_BITS   = 5,
    parameter int COLOR_BITS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req0_valid,
    output logic                      req0_ready,
    input  logic [ROW_BITS-1:0]       req0_row,
    input  logic [COL_BITS-1:0]       req0_col,
    input  logic [3*COLOR_BITS-1:0]   req0_rgb,
    input  logic                      req1_valid,
    output logic                      req1_ready,
    input  logic [ROW_BITS-1:0]       req1_row,
    input  logic [COL_BITS-1:0]       req1_col,
    input  logic [3*COLOR_BITS-1:0]   req1_rgb,
    input  logic                      swap_req,
    input  logic                      clear_req,
    input  logic                      frame_done,
    output logic                      front_buf,
    output logic                      wr_hi,
    output logic                      wr_lo,
    output logic [ROW_BITS+COL_BITS-1:0] wr_addr,
    output logic [3*COLOR_BITS-1:0]   wr_data,
    output logic                      swap_ack,
    output logic                      busy
);

    localparam int AW = ROW_BITS + COL_BITS;
    localparam int PW = 3 * COLOR_BITS;

    fb_state_t       state_q, state_d;
    logic            front_q, front_d;
    logic            wr_hi_d, wr_lo_d;
    logic [AW-1:0]   addr_d;
    logic [PW-1:0]   data_d;
    logic            ack_d;
    logic            arb_en;
    logic [1:0]      gnt;

`ifdef MATRIX_FB_CLEAR_EN
    // Counter spans one page: {row[3:0], col}
    logic [AW-2:0]   cnt_q, cnt_d;
    logic            pend_q, pend_d;
`else
    logic            unused_clear;
    assign unused_clear = clear_req;
`endif

    matrix_rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .en  (arb_en),
        .req ({req1_valid, req0_valid}),
        .gnt (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign front_buf  = front_q;
    assign busy       = (state_q == CLEAR) || (state_q == SWAP_WAIT);

    always_comb begin
        state_d = state_q;
        front_d = front_q;
        arb_en  = 1'b0;
        wr_hi_d = 1'b0;
        wr_lo_d = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        ack_d   = 1'b0;
`ifdef MATRIX_FB_CLEAR_EN
        cnt_d   = cnt_q;
        pend_d  = pend_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef MATRIX_FB_CLEAR_EN
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                    pend_d  = swap_req;
                end else
`endif
                if (swap_req) begin
                    state_d = SWAP_WAIT;
                end else begin
                    arb_en = 1'b1;
                    // Row MSB picks the hi/lo dpram; it is not part of the address.
                    if (gnt[0]) begin
                        wr_hi_d = req0_row[ROW_BITS-1];
                        wr_lo_d = ~req0_row[ROW_BITS-1];
                        addr_d  = {~front_q, req0_row[ROW_BITS-2:0], req0_col};
                        data_d  = req0_rgb;
                    end else if (gnt[1]) begin
                        wr_hi_d = req1_row[ROW_BITS-1];
                        wr_lo_d = ~req1_row[ROW_BITS-1];
                        addr_d  = {~front_q, req1_row[ROW_BITS-2:0], req1_col};
                        data_d  = req1_rgb;
                    end
                end
            end
`ifdef MATRIX_FB_CLEAR_EN
            CLEAR: begin
                // Both memories are written at once: one page sweep clears all 32 rows.
                wr_hi_d = 1'b1;
                wr_lo_d = 1'b1;
                addr_d  = {~front_q, cnt_q};
                cnt_d   = cnt_q + 1'b1;
                if (swap_req) begin
                    pend_d = 1'b1;
                end
                if (cnt_q == '1) begin
                    state_d = (pend_q || swap_req) ? SWAP_WAIT : IDLE;
                    pend_d  = 1'b0;
                end
            end
`endif
            SWAP_WAIT: begin
                if (frame_done) begin
                    front_d = ~front_q;
                    ack_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            front_q  <= 1'b0;
            wr_hi    <= 1'b0;
            wr_lo    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            swap_ack <= 1'b0;
        end else begin
            state_q  <= state_d;
            front_q  <= front_d;
            wr_hi    <= wr_hi_d;
            wr_lo    <= wr_lo_d;
            wr_addr  <= addr_d;
            wr_data  <= data_d;
            swap_ack <= ack_d;
        end
    end

`ifdef MATRIX_FB_CLEAR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            pend_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pend_q <= pend_d;
        end
    end
`endif

endmodule

// File: tb/tb_matrix_fb_write_ctrl.sv
// tb_matrix_fb_write_ctrl
// Directed bench for matrix_fb_write_ctrl with hand-computed expectations.
// Inputs are driven 1 ns after the rising edge; registered outputs are
// sampled at that point, combinational ready after a further 1 ns.
module tb_matrix_fb_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [4:0]  req0_row, req0_col, req1_row, req1_col;
    logic [11:0] req0_rgb, req1_rgb;
    logic        swap_req, clear_req, frame_done;
    logic        front_buf, wr_hi, wr_lo, swap_ack, busy;
    logic [9:0]  wr_addr;
    logic [11:0] wr_data;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    matrix_fb_write_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_row   (req0_row),
        .req0_col   (req0_col),
        .req0_rgb   (req0_rgb),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_row   (req1_row),
        .req1_col   (req1_col),
        .req1_rgb   (req1_rgb),
        .swap_req   (swap_req),
        .clear_req  (clear_req),
        .frame_done (frame_done),
        .front_buf  (front_buf),
        .wr_hi      (wr_hi),
        .wr_lo      (wr_lo),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .swap_ack   (swap_ack),
        .busy       (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {wr_hi, wr_lo, swap_ack, busy, front_buf, wr_addr, wr_data}
    function automatic logic [30:0] outs();
        return {wr_hi, wr_lo, swap_ack, busy, front_buf, wr_addr, wr_data};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        swap_req = 0; clear_req = 0; frame_done = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        req0_row = 0; req0_col = 0; req0_rgb = 0;
        req1_row = 0; req1_col = 0; req1_rgb = 0;
        do_reset();

        // Reset state
        chk("rst_outs", {1'b0, outs()}, 32'h0);
        #1;
        chk("rst_ready", {req1_ready, req0_ready}, 2'b00);

        // Single write, req0 row 3 col 7
        req0_valid = 1; req0_row = 5'd3; req0_col = 5'd7; req0_rgb = 12'hF0A;
        #1;
        chk("w1_ready", {req1_ready, req0_ready}, 2'b01);
        tick();
        req0_valid = 0;
        chk("w1_en",   {wr_hi, wr_lo}, 2'b01);
        chk("w1_addr", wr_addr, 10'h267);
        chk("w1_data", wr_data, 12'hF0A);
        tick();
        chk("w1_pulse", {wr_hi, wr_lo}, 2'b00);

        // Round robin from fresh reset: grants 0,1,0,1
        do_reset();
        req0_valid = 1; req0_row = 5'd20; req0_col = 5'd1;  req0_rgb = 12'h123;
        req1_valid = 1; req1_row = 5'd5;  req1_col = 5'd30; req1_rgb = 12'hABC;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready", {req1_ready, req0_ready}, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            if (i % 2 == 0)
                chk("rr_wr0", {wr_hi, wr_lo, wr_addr, wr_data}, {2'b10, 10'h281, 12'h123});
            else
                chk("rr_wr1", {wr_hi, wr_lo, wr_addr, wr_data}, {2'b01, 10'h2BE, 12'hABC});
        end
        req1_valid = 0;
        req0_valid = 0;
        tick();

        // Swap with frame_done 10 cycles later
        req0_valid = 1; req0_row = 5'd3; req0_col = 5'd7; req0_rgb = 12'h0F0;
        swap_req = 1;
        #1;
        chk("sw_noready", req0_ready, 1'b0);
        tick();
        swap_req = 0;
        chk("sw_busy", busy, 1'b1);
        for (int i = 1; i < 10; i++) begin
            #1;
            chk("sw_wait_ready", {req0_ready, wr_lo, front_buf}, 3'b000);
            tick();
        end
        frame_done = 1;
        #1;
        chk("sw_fd_ready", req0_ready, 1'b0);
        tick();
        frame_done = 0;
        chk("sw_flip", {swap_ack, front_buf, busy}, 3'b110);
        #1;
        chk("sw_ready_back", req0_ready, 1'b1);
        tick();
        req0_valid = 0;
        chk("sw_addr", {wr_lo, wr_addr, wr_data}, {1'b1, 10'h067, 12'h0F0});
        chk("sw_ack_pulse", swap_ack, 1'b0);

        // swap_req coincident with frame_done: flip waits for the next one
        swap_req = 1; frame_done = 1;
        tick();
        swap_req = 0; frame_done = 0;
        chk("swc_noflip", {swap_ack, front_buf, busy}, 3'b011);
        tick(); tick(); tick();
        chk("swc_wait", {swap_ack, front_buf, busy}, 3'b011);
        frame_done = 1;
        tick();
        frame_done = 0;
        chk("swc_flip", {swap_ack, front_buf, busy}, 3'b100);
        tick();

`ifdef MATRIX_FB_CLEAR_EN
        // Clear with swap pending; front=0 so back=1 -> 0x200..0x3FF
        clear_req = 1; swap_req = 1; req0_valid = 1;
        #1;
        chk("clr_noready", req0_ready, 1'b0);
        tick();
        clear_req = 0; swap_req = 0; req0_valid = 0;
        for (int i = 0; i < 512; i++) begin
            tick();
            chk("clr_wr", {wr_hi, wr_lo, wr_data, wr_addr},
                {2'b11, 12'h000, 10'h200 + 10'(i)});
            frame_done = (i == 50);
            clear_req  = (i == 60);
        end
        frame_done = 0; clear_req = 0;
        chk("clr_front", front_buf, 1'b0);
        tick();
        chk("clr_swapwait", {wr_hi, wr_lo, busy, swap_ack}, 4'b0010);
        frame_done = 1;
        tick();
        frame_done = 0;
        chk("clr_flip", {swap_ack, front_buf, busy}, 3'b110);
        tick();

        // Reset at clear count 100
        clear_req = 1;
        tick();
        clear_req = 0;
        for (int i = 0; i < 100; i++) tick();
        chk("rc_clearing", {wr_hi, wr_lo, wr_addr}, {2'b11, 10'h063});
        rst = 1;
        tick();
        rst = 0;
        chk("rc_outs", {1'b0, outs()}, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rc_nowrite", {wr_hi, wr_lo, busy, front_buf}, 4'b0000);
        end
`else
        // clear_req ignored: request still granted, no busy
        clear_req = 1; req0_valid = 1;
        #1;
        chk("noclr_ready", req0_ready, 1'b1);
        tick();
        clear_req = 0; req0_valid = 0;
        chk("noclr_busy", {busy, wr_lo, wr_hi}, 3'b010);
        tick();
        chk("noclr_idle", {busy, wr_lo, wr_hi}, 3'b000);

        // Flip to front=1, then reset mid SWAP_WAIT
        swap_req = 1; tick(); swap_req = 0;
        frame_done = 1; tick(); frame_done = 0;
        chk("rs_front1", front_buf, 1'b1);
        swap_req = 1; tick(); swap_req = 0;
        chk("rs_busy", busy, 1'b1);
        rst = 1;
        tick();
        rst = 0;
        chk("rs_outs", {1'b0, outs()}, 32'h0);
        frame_done = 1;
        tick();
        frame_done = 0;
        chk("rs_noack", {swap_ack, front_buf, busy}, 3'b000);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
